// File: rtl/somador_bcd_seq_pkg.sv
// somador_pkg: shared definitions for the sequential BCD adder/subtractor.
//   state_e    : FSM states IDLE -> ADD -> CONV -> DONE
//   SEG_BLANK  : all segments off (active-low)
//   SEG_MINUS  : only segment g lit
//   min_digits : decimal digits needed to show 2^(width+1)-1
package somador_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    CONV,
    DONE
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;

  function automatic int unsigned min_digits(input int unsigned width);
    longint unsigned max_val;
    int unsigned     n;
    max_val = (64'd1 << (width + 1)) - 64'd1;
    n       = 1;
    while (max_val >= 64'd10) begin
      max_val = max_val / 64'd10;
      n       = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/somador_bcd_seq_if.sv
// somador_bcd_seq_if: request/result bundle for somador_bcd_seq.
//   start/sub/te0/x/y : request side (driven by master)
//   busy/done/neg/result/hex/hex_sign : status and display side (driven by slave)
interface somador_bcd_seq_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);

  logic                  start;
  logic                  sub;
  logic                  te0;
  logic [WIDTH-1:0]      x;
  logic [WIDTH-1:0]      y;
  logic                  busy;
  logic                  done;
  logic                  neg;
  logic [WIDTH:0]        result;
  logic [DIGITS*7-1:0]   hex;
  logic [6:0]            hex_sign;

  modport master (
    output start, sub, te0, x, y,
    input  busy, done, neg, result, hex, hex_sign
  );

  modport slave (
    input  start, sub, te0, x, y,
    output busy, done, neg, result, hex, hex_sign
  );

endinterface

// File: rtl/somador_bcd_seq_decod7seg.sv
// decod7seg: BCD digit to seven-segment pattern.
//   bcd : 4-bit BCD digit
//   seg : [a..g] active-low; codes 10-15 give a blank display
module decod7seg
  import somador_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 7'b0000001;
      4'd1: seg = 7'b1001111;
      4'd2: seg = 7'b0010010;
      4'd3: seg = 7'b0000110;
      4'd4: seg = 7'b1001100;
      4'd5: seg = 7'b0100100;
      4'd6: seg = 7'b0100000;
      4'd7: seg = 7'b0001111;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/somador_bcd_seq.sv
// somador_bcd_seq: sequential adder/subtractor with decimal 7-segment output.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of somador_bcd_seq_if
//                start/sub/te0/x/y in; busy/done/neg/result/hex/hex_sign out
// The magnitude is converted to BCD by double-dabble, one bit per clock.
module somador_bcd_seq
  import somador_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIGITS   = 3,
  parameter bit          BLANK_LZ = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  somador_bcd_seq_if.slave bus
);

  localparam int unsigned MW = WIDTH + 1;
  localparam int unsigned BW = DIGITS * 4;
  localparam int unsigned CW = $clog2(WIDTH + 2);

  if (WIDTH < 2 || DIGITS < min_digits(WIDTH)) begin : g_bad_params
    $error("somador_bcd_seq: WIDTH must be >= 2 and DIGITS large enough for 2^(WIDTH+1)-1");
  end

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    x_q, x_d, y_q, y_d;
  logic                te0_q, te0_d, sub_q, sub_d;
  logic [MW-1:0]       mag_q, mag_d;
  logic                neg_pend_q, neg_pend_d;
  logic [MW-1:0]       shift_q, shift_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [MW-1:0]       result_q, result_d;
  logic                neg_q, neg_d;
  logic [DIGITS*7-1:0] hex_q, hex_d;
  logic [6:0]          hex_sign_q, hex_sign_d;

  logic [MW-1:0]       mag_c;
  logic                neg_c;
  logic [BW-1:0]       bcd_adj, bcd_step;
  logic [MW-1:0]       shift_step;
  logic [DIGITS*7-1:0] seg_raw, hex_disp;

  // Magnitude and sign of the latched operation; x==y yields +0.
  always_comb begin
    mag_c = '0;
    neg_c = 1'b0;
    if (!sub_q) begin
      mag_c = {1'b0, x_q} + {1'b0, y_q} + MW'(te0_q);
    end else if (x_q >= y_q) begin
      mag_c = {1'b0, x_q - y_q};
    end else begin
      mag_c = {1'b0, y_q - x_q};
      neg_c = 1'b1;
    end
  end

  // One double-dabble step: add 3 to nibbles >=5, then shift in next bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
    bcd_step   = {bcd_adj[BW-2:0], shift_q[MW-1]};
    shift_step = {shift_q[MW-2:0], 1'b0};
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    decod7seg u_dec (
      .bcd (bcd_step[4*g +: 4]),
      .seg (seg_raw[7*g +: 7])
    );
  end

  // Digit k>0 is blanked while it and every higher digit are zero.
  always_comb begin
    logic        nz;
    int unsigned k;
    hex_disp = seg_raw;
    nz       = 1'b0;
    k        = 0;
    if (BLANK_LZ) begin
      for (int unsigned i = 0; i + 1 < DIGITS; i++) begin
        k  = DIGITS - 1 - i;
        nz = nz | (bcd_step[4*k +: 4] != 4'd0);
        if (!nz) begin
          hex_disp[7*k +: 7] = SEG_BLANK;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    te0_d      = te0_q;
    sub_d      = sub_q;
    mag_d      = mag_q;
    neg_pend_d = neg_pend_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    neg_d      = neg_q;
    hex_d      = hex_q;
    hex_sign_d = hex_sign_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.x;
          y_d     = bus.y;
          te0_d   = bus.te0;
          sub_d   = bus.sub;
          state_d = ADD;
        end
      end
      ADD: begin
        mag_d      = mag_c;
        neg_pend_d = neg_c;
        shift_d    = mag_c;
        bcd_d      = '0;
        cnt_d      = '0;
        state_d    = CONV;
      end
      CONV: begin
        shift_d = shift_step;
        bcd_d   = bcd_step;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH)) begin
          result_d   = mag_q;
          neg_d      = neg_pend_q;
          hex_d      = hex_disp;
          hex_sign_d = neg_pend_q ? SEG_MINUS : SEG_BLANK;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      te0_q      <= 1'b0;
      sub_q      <= 1'b0;
      mag_q      <= '0;
      neg_pend_q <= 1'b0;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      neg_q      <= 1'b0;
      hex_q      <= '1;
      hex_sign_q <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      te0_q      <= te0_d;
      sub_q      <= sub_d;
      mag_q      <= mag_d;
      neg_pend_q <= neg_pend_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      neg_q      <= neg_d;
      hex_q      <= hex_d;
      hex_sign_q <= hex_sign_d;
    end
  end

  assign bus.busy     = (state_q == ADD) || (state_q == CONV);
  assign bus.done     = (state_q == DONE);
  assign bus.neg      = neg_q;
  assign bus.result   = result_q;
  assign bus.hex      = hex_q;
  assign bus.hex_sign = hex_sign_q;

endmodule

// File: tb/tb_somador_bcd_seq.sv
// tb_somador_bcd_seq: self-checking bench for somador_bcd_seq (WIDTH=8, DIGITS=3).
// Two instances share stimulus: one with leading-zero blanking, one without.
module tb_somador_bcd_seq;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIGITS = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  somador_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();
  somador_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus_nb ();

  assign bus_nb.start = bus.start;
  assign bus_nb.sub   = bus.sub;
  assign bus_nb.te0   = bus.te0;
  assign bus_nb.x     = bus.x;
  assign bus_nb.y     = bus.y;

  somador_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  somador_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1'b0)) u_dut_nb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nb)
  );

  localparam logic [6:0] BL = 7'b1111111;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return BL;
    endcase
  endfunction

  // Decimal display pattern of a non-negative value.
  function automatic logic [DIGITS*7-1:0] exp_hex(input int mag, input bit blank);
    logic [DIGITS*7-1:0] r;
    int p;
    p = 1;
    r = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (blank && k > 0 && mag < p) r[7*k +: 7] = BL;
      else                           r[7*k +: 7] = seg_of((mag / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Issues one request and watches 30 edges: first done edge, done count,
  // and whether busy was high on every cycle before done.
  task automatic run_op(input int xv, input int yv, input bit te0v, input bit subv,
                        input bit extra, output int lat, output int ndone, output bit busy_ok);
    @(negedge clk);
    bus.x = xv[WIDTH-1:0]; bus.y = yv[WIDTH-1:0]; bus.te0 = te0v; bus.sub = subv; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.x = WIDTH'($urandom); bus.y = WIDTH'($urandom);
    bus.te0 = 1'($urandom); bus.sub = 1'($urandom);
    lat = -1; ndone = 0; busy_ok = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      bus.start = extra && (k == 3 || k == WIDTH + 3);
      @(posedge clk); #1;
      if (bus.done) begin
        ndone++;
        if (lat < 0) lat = k;
        if (bus.busy) busy_ok = 1'b0;
      end else if (lat < 0 && !bus.busy) begin
        busy_ok = 1'b0;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.sub = 0; bus.te0 = 0; bus.x = '0; bus.y = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.neg !== 1'b0) begin errors++; $display("FAIL reset_neg got %b exp 0", bus.neg); end
    checks++; if (bus.result !== '0) begin errors++; $display("FAIL reset_result got %0d exp 0", bus.result); end
    checks++; if (bus.hex !== {BL, BL, BL}) begin errors++; $display("FAIL reset_hex got %b exp all ones", bus.hex); end
    checks++; if (bus.hex_sign !== BL) begin errors++; $display("FAIL reset_hex_sign got %b exp %b", bus.hex_sign, BL); end
    checks++; if (bus_nb.hex !== {BL, BL, BL}) begin errors++; $display("FAIL reset_hex_nb got %b exp all ones", bus_nb.hex); end
    checks++; if (bus_nb.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_nb got %b exp 0", bus_nb.busy); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 || bus.hex !== {BL, BL, BL} || bus.hex_sign !== BL) begin
        errors++;
        $display("FAIL idle_hold cycle %0d got busy=%b done=%b result=%0d hex=%b exp 0 0 0 all ones", i, bus.busy, bus.done, bus.result, bus.hex);
      end
    end
  endtask

  task automatic test_max_add();
    int lat, nd; bit bok;
    run_op(255, 255, 1'b1, 1'b0, 1'b0, lat, nd, bok);
    checks++; if (lat !== 10) begin errors++; $display("FAIL max_latency got %0d exp 10", lat); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL max_done_count got %0d exp 1", nd); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL max_busy got %b exp 1", bok); end
    checks++; if (bus.result !== 9'd511 || bus.neg !== 1'b0) begin errors++; $display("FAIL max_result got %0d neg %b exp 511 neg 0", bus.result, bus.neg); end
    checks++; if (bus.hex !== {7'b0100100, 7'b1001111, 7'b1001111}) begin errors++; $display("FAIL max_hex got %b exp 010010010011111001111", bus.hex); end
    checks++; if (bus.hex_sign !== BL) begin errors++; $display("FAIL max_hex_sign got %b exp %b", bus.hex_sign, BL); end
  endtask

  task automatic test_sub_neg();
    int lat, nd; bit bok;
    run_op(3, 10, 1'b1, 1'b1, 1'b0, lat, nd, bok);
    checks++; if (bus.result !== 9'd7 || bus.neg !== 1'b1) begin errors++; $display("FAIL subneg_result got %0d neg %b exp 7 neg 1", bus.result, bus.neg); end
    checks++; if (bus.hex !== {BL, BL, 7'b0001111}) begin errors++; $display("FAIL subneg_hex got %b exp blank blank 0001111", bus.hex); end
    checks++; if (bus.hex_sign !== 7'b1111110) begin errors++; $display("FAIL subneg_hex_sign got %b exp 1111110", bus.hex_sign); end
  endtask

  task automatic test_zero();
    int lat, nd; bit bok;
    run_op(0, 0, 1'b0, 1'b0, 1'b0, lat, nd, bok);
    checks++; if (bus.result !== '0 || bus.neg !== 1'b0) begin errors++; $display("FAIL zero_result got %0d neg %b exp 0 neg 0", bus.result, bus.neg); end
    checks++; if (bus.hex !== {BL, BL, 7'b0000001}) begin errors++; $display("FAIL zero_hex got %b exp blank blank 0000001", bus.hex); end
    checks++; if (bus_nb.hex !== {3{7'b0000001}}) begin errors++; $display("FAIL zero_hex_nb got %b exp three zeros", bus_nb.hex); end
    checks++; if (bus_nb.result !== '0) begin errors++; $display("FAIL zero_result_nb got %0d exp 0", bus_nb.result); end
  endtask

  task automatic test_extra_start();
    int lat, nd; bit bok;
    run_op(100, 23, 1'b0, 1'b0, 1'b1, lat, nd, bok);
    checks++; if (nd !== 1) begin errors++; $display("FAIL extra_done_count got %0d exp 1", nd); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL extra_latency got %0d exp 10", lat); end
    checks++; if (bus.result !== 9'd123) begin errors++; $display("FAIL extra_result got %0d exp 123", bus.result); end
    checks++; if (bus.hex !== exp_hex(123, 1'b1)) begin errors++; $display("FAIL extra_hex got %b exp %b", bus.hex, exp_hex(123, 1'b1)); end
  endtask

  task automatic test_random();
    int lat, nd, xv, yv, diff, mag; bit bok, te0v, subv;
    logic [WIDTH:0] em;
    for (int i = 0; i < 40; i++) begin
      xv = int'($urandom_range(0, 255));
      yv = (i % 8 == 0) ? xv : int'($urandom_range(0, 255));
      te0v = 1'($urandom); subv = 1'($urandom);
      run_op(xv, yv, te0v, subv, 1'b0, lat, nd, bok);
      diff = subv ? xv - yv : xv + yv + int'(te0v);
      mag  = (diff < 0) ? -diff : diff;
      em   = mag[WIDTH:0];
      checks++;
      if (lat !== 10 || nd !== 1 || bok !== 1'b1) begin
        errors++; $display("FAIL rand_timing #%0d got lat=%0d ndone=%0d busy_ok=%b exp 10 1 1", i, lat, nd, bok);
      end
      checks++;
      if (bus.result !== em || bus.neg !== (diff < 0)) begin
        errors++; $display("FAIL rand_result #%0d x=%0d y=%0d te0=%b sub=%b got %0d neg %b exp %0d neg %b", i, xv, yv, te0v, subv, bus.result, bus.neg, mag, diff < 0);
      end
      checks++;
      if (bus.hex !== exp_hex(mag, 1'b1) || bus_nb.hex !== exp_hex(mag, 1'b0)) begin
        errors++; $display("FAIL rand_hex #%0d got %b/%b exp %b/%b", i, bus.hex, bus_nb.hex, exp_hex(mag, 1'b1), exp_hex(mag, 1'b0));
      end
      checks++;
      if (bus.hex_sign !== ((diff < 0) ? 7'b1111110 : BL)) begin
        errors++; $display("FAIL rand_hex_sign #%0d got %b neg_exp %b", i, bus.hex_sign, diff < 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, nd; bit bok;
    @(negedge clk);
    bus.x = 8'd200; bus.y = 8'd50; bus.te0 = 0; bus.sub = 1; bus.start = 1;
    @(posedge clk); #1; bus.start = 0;
    repeat (5) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midreset_ctrl got busy=%b done=%b exp 0 0", bus.busy, bus.done); end
    checks++; if (bus.result !== '0 || bus.neg !== 1'b0) begin errors++; $display("FAIL midreset_result got %0d neg %b exp 0 0", bus.result, bus.neg); end
    checks++; if (bus.hex !== {BL, BL, BL} || bus.hex_sign !== BL) begin errors++; $display("FAIL midreset_hex got %b sign %b exp all ones", bus.hex, bus.hex_sign); end
    @(negedge clk); rst_n = 1'b1;
    run_op(9, 1, 1'b0, 1'b0, 1'b0, lat, nd, bok);
    checks++; if (lat !== 10 || nd !== 1) begin errors++; $display("FAIL postreset_timing got lat=%0d ndone=%0d exp 10 1", lat, nd); end
    checks++; if (bus.result !== 9'd10) begin errors++; $display("FAIL postreset_result got %0d exp 10", bus.result); end
    checks++; if (bus.hex !== {BL, 7'b1001111, 7'b0000001}) begin errors++; $display("FAIL postreset_hex got %b exp blank 1001111 0000001", bus.hex); end
  endtask

  initial begin
    test_reset();
    test_max_add();
    test_sub_neg();
    test_zero();
    test_extra_start();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/somador_bcd_seq.md
Name: somador_bcd_seq

Overview:
- Parametrised sequential adder/subtractor with decimal seven-segment output.
- Latches two WIDTH-bit operands on a start strobe and computes the sum (with carry-in) or the signed difference.
- Converts the magnitude to BCD with an iterative shift-add-3 (double-dabble) engine, one bit per clock.
- Drives DIGITS active-low seven-segment displays plus a sign display; sits between board switches/keys and the HEX displays.

Parameters:
- WIDTH, 8, operand width in bits (≥2).
- DIGITS, 3, number of decimal displays; must satisfy 10^DIGITS > 2^(WIDTH+1)-1, otherwise elaboration error.
- BLANK_LZ, 1, 1 = blank leading-zero digits (units digit always shown); 0 = show all zeros.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- sub  in  1  0 = x+y+te0, 1 = x−y (te0 ignored).
- te0  in  1  carry-in for add mode.
- x  in  WIDTH  operand A, unsigned.
- y  in  WIDTH  operand B, unsigned.
- busy  out  1  high in ADD and CONV.
- done  out  1  one-cycle pulse when displays update.
- neg  out  1  registered sign of last result (1 = negative).
- result  out  WIDTH+1  registered magnitude of last result, binary.
- hex  out  DIGITS*7  digit k in bits [7k+6:7k], k=0 units; per digit bit order a..g, active-low.
- hex_sign  out  7  minus display, same encoding.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, done=0, neg=0, result=0; all hex and hex_sign = 7'b1111111 (blank). Reset mid-operation aborts and discards the result.
- States: IDLE → ADD → CONV → DONE → IDLE.
- IDLE, start=1 at edge E0: latch x, y, te0 and sub; go to ADD.
- ADD, edge E1: compute the (WIDTH+1)-bit magnitude and sign, then load the shift register and clear the BCD field to 0; go to CONV.
  - Add mode: mag = x+y+te0, neg=0.
  - Sub mode: if x≥y then mag = x−y, neg=0; else mag = y−x, neg=1.
  - x==y gives mag=0, neg=0; no negative zero.
- CONV: one double-dabble step per edge, so WIDTH+1 steps at edges E2..E(WIDTH+2).
  - Each step: for every BCD nibble ≥5, add 3; then shift left one position, injecting the next bit MSB-first.
  - The last step's edge goes to DONE and registers result, neg, hex and hex_sign.
- DONE: done=1 and busy=0 for exactly one cycle (the cycle after edge E(WIDTH+2)); next edge goes to IDLE.
- Latency: start sampled at E0 → done high after E(WIDTH+2); WIDTH=8 gives 10 edges.
- start while busy or in DONE is ignored. Operand changes after E0 have no effect.
- Outputs hold their last values until the next DONE.
- Leading-zero blanking (BLANK_LZ=1): digit k>0 is blank if it and all higher digits are 0.
- hex_sign = 7'b1111110 (g segment only) when neg=1, else blank.
- Segment codes [a..g], active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- A BCD nibble >9 cannot occur; the decoder outputs blank for 10–15.

Decomposition:
- Shared package somador_pkg: state enum (IDLE, ADD, CONV, DONE); SEG_BLANK=7'b1111111; SEG_MINUS=7'b1111110; function for minimum digits given a width, used in the DIGITS elaboration check.
- One sub-module, decod7seg: 4-bit BCD in, 7-bit active-low [a..g] out. Combinational; instantiated DIGITS times via generate.
- FSM, shift/add-3 datapath and blanking logic live in somador_bcd_seq.

Test Plan:
- Hold rst_n=0 → busy=0, done=0, result=0, all hex and hex_sign=1111111. Release, no start → outputs unchanged for 20 cycles.
- WIDTH=8: x=255, y=255, te0=1, sub=0, start → done exactly after 10th edge; result=511, neg=0; hex digits 2..0 = 0100100, 1001111, 1001111; hex_sign blank.
- sub=1, x=3, y=10 → result=7, neg=1; units=0001111; digits 1,2 blank; hex_sign=1111110.
- x=0, y=0, te0=0, sub=0 → result=0; units=0000001; digits 1,2 blank. Repeat with BLANK_LZ=0 → all three digits =0000001.
- Pulse start again at edges E3 and E(WIDTH+3) during an operation with x=100, y=23 → single done pulse, result=123; extra starts ignored, no second done.
- Assert rst_n=0 at edge E5 of an operation → outputs blank immediately (async). Release and start x=9, y=1 → result=10, displays 0000001, 1001111, blank.
